// File: rtl/strength_resolve_monitor.sv
// strength_resolve_monitor
// Resolves two strength-tagged drivers onto one net, registers the 4-state
// result, filters it for stability, counts qualified rising edges and raises
// a sticky done flag once the edge target is reached.
module strength_resolve_monitor #(
  parameter int STABLE_CYCLES = 3,
  parameter int EDGE_TARGET   = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_val,
  input  logic [1:0]       a_str0,
  input  logic [1:0]       a_str1,
  input  logic             b_val,
  input  logic [1:0]       b_str0,
  input  logic [1:0]       b_str1,
  output logic             res_val,
  output logic             res_x,
  output logic             res_z,
  output logic             q,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             done
);

  // stab_cnt only ever holds 0 .. STABLE_CYCLES-1
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TARGET    = CNT_W'(EDGE_TARGET);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [1:0]       sa;
  logic [1:0]       sb;
  logic             comb_val;
  logic             comb_x;
  logic             comb_z;
  // set once the result registers hold a real post-reset sample rather than
  // the reset value, so an undriven net keeps the FSM in IDLE
  logic             res_seen;
  logic             sample_valid;
  logic [SW-1:0]    stab_cnt;
  logic             q_d;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] edge_cnt_next;
  logic             done_next;

  // Strength resolution of the two drivers for the current cycle
  always_comb begin
    sa       = a_val ? a_str1 : a_str0;
    sb       = b_val ? b_str1 : b_str0;
    comb_val = 1'b0;
    comb_x   = 1'b0;
    comb_z   = 1'b0;
    if ((sa == 2'd0) && (sb == 2'd0)) begin
      comb_z = 1'b1;
    end else if (sa > sb) begin
      comb_val = a_val;
    end else if (sb > sa) begin
      comb_val = b_val;
    end else if (a_val == b_val) begin
      comb_val = a_val;
    end else begin
      comb_x = 1'b1;
    end
  end

  // Register the resolved net state
  always_ff @(posedge clk) begin
    if (rst) begin
      res_val  <= 1'b0;
      res_x    <= 1'b0;
      res_z    <= 1'b0;
      res_seen <= 1'b0;
    end else begin
      res_val  <= comb_val;
      res_x    <= comb_x;
      res_z    <= comb_z;
      res_seen <= 1'b1;
    end
  end

  assign sample_valid = ~res_x & ~res_z;

  // Stability filter: q changes only after STABLE_CYCLES consecutive valid
  // differing samples; any X/Z or agreeing sample restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= 1'b0;
      stab_cnt <= '0;
    end else if (!sample_valid) begin
      stab_cnt <= '0;
    end else if (res_val == q) begin
      stab_cnt <= '0;
    end else if (stab_cnt == STAB_LAST) begin
      q        <= res_val;
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt + SW'(1);
    end
  end

  // Delayed copy of q for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      q_d <= 1'b0;
    end else begin
      q_d <= q;
    end
  end

  // FSM state, edge counter and done flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      edge_cnt <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      edge_cnt <= edge_cnt_next;
      done     <= done_next;
    end
  end

  // FSM next state and counter update; DONE freezes the count
  always_comb begin
    state_next    = state;
    edge_cnt_next = edge_cnt;
    done_next     = done;
    case (state)
      IDLE: begin
        if (res_seen && sample_valid) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (q && !q_d && (edge_cnt != TARGET)) begin
          edge_cnt_next = edge_cnt + CNT_W'(1);
          if (edge_cnt_next == TARGET) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = RUN;
          end
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        state_next = DONE;
        done_next  = 1'b1;
      end
      default: begin
        state_next    = IDLE;
        edge_cnt_next = '0;
        done_next     = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/strength_resolve_monitor.md
Name: strength_resolve_monitor

Overview:
Upstream/downstream pair for a two-driver strength-tagged net. Resolves two drivers, each carrying a value plus separate 0/1 drive strengths, per Verilog strength rules. Registers the resolved 4-state result, qualifies it with a stability filter, counts qualified rising edges, and raises a sticky done flag once a target count is reached.

Parameters:
STABLE_CYCLES, 3, consecutive valid registered samples of a new level needed before q changes; must be >= 1.
EDGE_TARGET, 4, qualified rising edges of q that assert done; must be >= 1 and < 2^CNT_W.
CNT_W, 8, width of edge_cnt.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  synchronous reset, active-high.
a_val  input  1  value driven by driver A.
a_str0  input  2  strength driver A applies when a_val=0 (0 highz, 1 weak, 2 pull, 3 strong).
a_str1  input  2  strength driver A applies when a_val=1.
b_val  input  1  value driven by driver B.
b_str0  input  2  strength driver B applies when b_val=0.
b_str1  input  2  strength driver B applies when b_val=1.
res_val  output  1  registered resolved value; 0 when res_x or res_z is set.
res_x  output  1  registered conflict flag: equal nonzero strengths with opposite values.
res_z  output  1  registered no-driver flag: both effective strengths are 0.
q  output  1  filtered, qualified level.
edge_cnt  output  CNT_W  count of qualified rising edges of q.
done  output  1  sticky; set when edge_cnt reaches EDGE_TARGET.

Behaviour:
- Effective strength: sA = a_val ? a_str1 : a_str0; sB is defined the same way for driver B.
- Combinational resolve:
  - sA=sB=0 gives Z.
  - sA>sB gives a_val; sB>sA gives b_val.
  - sA=sB>0 with a_val=b_val gives that value; with a_val!=b_val it gives X.
- Result is registered with 1-cycle latency into res_val/res_x/res_z. Exactly one of {valid, X, Z} holds per cycle.
- Filter, operating on the registered samples:
  - A sample is valid when res_x=0 and res_z=0.
  - Invalid sample: stab_cnt clears, q holds.
  - Valid sample equal to q: stab_cnt clears.
  - Valid sample different from q: stab_cnt increments. On the STABLE_CYCLES-th consecutive such sample, q takes the sample value at that edge and stab_cnt clears.
  - Net effect: a clean input change held steady becomes visible on q STABLE_CYCLES+1 cycles after it is applied.
- FSM states are IDLE, RUN and DONE.
  - IDLE: entered on reset; moves to RUN on the first valid registered sample. Edges are not counted in IDLE.
  - RUN: a registered rising-edge detect (q=1, q_d=0) increments edge_cnt on the following cycle.
    - When the increment makes edge_cnt equal EDGE_TARGET, the FSM moves to DONE and done=1 in the same cycle edge_cnt shows the target.
  - DONE: edge_cnt and done hold; further q edges are ignored; only rst exits. The resolver and filter keep running.
- Reset values: res_val=0, res_x=0, res_z=0, q=0, q_d=0, stab_cnt=0, edge_cnt=0, done=0, state=IDLE.
- rst asserted mid-operation restores all reset values at that edge and overrides every other update in the same cycle.
- Boundary conditions:
  - X/Z interrupting a pending transition restarts stability counting from zero.
  - With STABLE_CYCLES=1, q follows any valid differing sample one edge after it is registered.
  - edge_cnt never wraps.

Test Plan:
1. A: a_val=1, a_str1=3. B: b_val=0, b_str0=2. Result: res_val=1 and res_x=0 one cycle later. With the drivers swapped (A pull0, B strong1) the result is still 1.
2. A pull1 and B pull0 (a_str1=2, b_str0=2). Result: res_x=1, res_val=0. q holds its prior value. A pending transition (stab_cnt=2) aborts and needs a full 3 new samples.
3. Both drivers highz on their driven value. Result: res_z=1; FSM remains IDLE after reset until a valid sample arrives, then enters RUN.
4. STABLE_CYCLES=3 with a strong1 pulse lasting 2 cycles: q stays 0. Pulse lasting 3 or more cycles: q=1 exactly 4 cycles after the input change.
5. Four clean high/low pulses of 5 cycles each: edge_cnt steps 1, 2, 3, 4 and done=1 with edge_cnt=4. A fifth pulse leaves edge_cnt=4 and done=1.
6. rst asserted for one cycle at edge_cnt=2 while a q transition is pending. Next cycle: every output is 0 and state is IDLE. Counting then resumes from 0.
